// File: rtl/pipe_pkg.sv
// Shared pipeline types: skid buffer state encoding and occupancy decode.
package pipe_pkg;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_BUSY  = 2'd1,
      S_FULL  = 2'd2
   } skid_state_t;

   function automatic logic [1:0] state_level(input skid_state_t s);
      logic [1:0] lvl;
      lvl = 2'd0;
      unique case (s)
         S_EMPTY: lvl = 2'd0;
         S_BUSY:  lvl = 2'd1;
         S_FULL:  lvl = 2'd2;
         default: lvl = 2'd0;
      endcase
      return lvl;
   endfunction

endpackage

// File: rtl/skid_buffer_en_reg.sv
// Enabled data register with synchronous active-high reset to RST_VAL.
module skid_buffer_en_reg #(
   parameter int unsigned           WIDTH   = 32,
   parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] data_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= RST_VAL;
      end else if (en_i) begin
         data_q <= d_i;
      end
   end

   assign q_o = data_q;

endmodule

// File: rtl/skid_buffer.sv
// Two-entry skid buffer: registered valid/ready on both sides, main register drives out_data.
module skid_buffer
   import pipe_pkg::*;
#(
   parameter int unsigned      WIDTH   = 32,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [1:0]       level
);

   skid_state_t      state_q, state_d;
   logic             in_fire, out_fire;
   logic             main_en, skid_en, main_sel_skid;
   logic [WIDTH-1:0] main_d, skid_q;

   // Handshake outputs decode from state only, so no ready/valid combinational paths.
   assign out_valid = (state_q != S_EMPTY);
   assign in_ready  = (state_q != S_FULL);
   assign level     = state_level(state_q);

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;
   assign main_d   = main_sel_skid ? skid_q : in_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      main_en       = 1'b0;
      skid_en       = 1'b0;
      main_sel_skid = 1'b0;
      if (flush) begin
         // Flush drops everything, including any handshake in the same cycle.
         state_d = S_EMPTY;
      end else begin
         unique case (state_q)
            S_EMPTY: begin
               if (in_fire) begin
                  main_en = 1'b1;
                  state_d = S_BUSY;
               end
            end
            S_BUSY: begin
               if (in_fire && out_fire) begin
                  main_en = 1'b1;
               end else if (in_fire) begin
                  skid_en = 1'b1;
                  state_d = S_FULL;
               end else if (out_fire) begin
                  state_d = S_EMPTY;
               end
            end
            S_FULL: begin
               if (out_fire) begin
                  main_en       = 1'b1;
                  main_sel_skid = 1'b1;
                  state_d       = S_BUSY;
               end
            end
            default: state_d = S_EMPTY;
         endcase
      end
   end

   skid_buffer_en_reg #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
   ) u_main_reg (
      .clk  (clk),
      .rst  (rst),
      .en_i (main_en),
      .d_i  (main_d),
      .q_o  (out_data)
   );

   skid_buffer_en_reg #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
   ) u_skid_reg (
      .clk  (clk),
      .rst  (rst),
      .en_i (skid_en),
      .d_i  (in_data),
      .q_o  (skid_q)
   );

endmodule

// File: tb/tb_skid_buffer.sv
// Scoreboard bench for skid_buffer: occupancy model pushes accepted data, monitor checks output beats.
module tb_skid_buffer;

   localparam int unsigned WIDTH  = 32;
   localparam logic [31:0] TB_RST = 32'hC0DE_0001;

   logic             clk = 1'b0;
   logic             rst, flush, in_valid, out_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_ready, out_valid;
   logic [WIDTH-1:0] out_data;
   logic [1:0]       level;

   logic [31:0] exp_q[$];
   logic [1:0]  mlevel = 2'd0;
   logic        mon_en = 1'b0;
   int          vectors = 0;
   int          errors  = 0;
   int          popped  = 0;

   always #5 clk = ~clk;

   skid_buffer #(
      .WIDTH   (WIDTH),
      .RST_VAL (TB_RST)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .level     (level)
   );

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      vectors++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h want %h at %0t", name, act, expv, $time);
      end
   endfunction

   // Reference occupancy model; accepted data enters the expected queue here.
   initial begin
      forever begin
         @(posedge clk);
         if (rst === 1'b1 || flush === 1'b1) begin
            mlevel = 2'd0;
            exp_q.delete();
         end else begin
            logic mi, mo;
            mi = (in_valid === 1'b1) && (mlevel != 2'd2);
            mo = (out_ready === 1'b1) && (mlevel != 2'd0);
            if (mi) exp_q.push_back(in_data);
            mlevel = mlevel + 2'(mi) - 2'(mo);
         end
      end
   end

   // Monitor: compare handshake flags, level and head data every cycle; retire on out_fire.
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            chk("out_valid", 32'(out_valid), 32'(mlevel != 2'd0));
            chk("in_ready", 32'(in_ready), 32'(mlevel != 2'd2));
            chk("level", 32'(level), 32'(mlevel));
            if (mlevel != 2'd0 && exp_q.size() > 0) chk("out_data", out_data, exp_q[0]);
            if (mlevel != 2'd0 && out_ready === 1'b1 && flush !== 1'b1 && rst !== 1'b1
                && exp_q.size() > 0) begin
               void'(exp_q.pop_front());
               popped++;
            end
         end
      end
   end

   task automatic drive(input logic v, input logic [31:0] d, input logic ordy, input logic fl,
                        input logic r, output logic acc);
      in_valid  = v;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      rst       = r;
      @(negedge clk);
      acc = v && !fl && !r && (mlevel != 2'd2);
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] d, input logic ordy);
      logic acc;
      int   n;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 20) begin
         drive(1'b1, d, ordy, 1'b0, 1'b0, acc);
         n++;
      end
      if (!acc) chk("push_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle(input logic ordy);
      logic acc;
      drive(1'b0, 32'h0, ordy, 1'b0, 1'b0, acc);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (mlevel != 2'd0 && n < 20) begin
         idle(1'b1);
         n++;
      end
      chk("drain_level", 32'(mlevel), 32'd0);
   endtask

   initial begin
      logic acc;
      int   sent, cyc, pop0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      flush     = 1'b0;
      rst       = 1'b1;

      drive(1'b1, 32'hBAD0_0000, 1'b1, 1'b0, 1'b1, acc);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, acc);
      chk("rst_out_data", out_data, TB_RST);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      mon_en = 1'b1;

      // Single beat with one cycle latency.
      push(32'h11, 1'b1);
      chk("lat_out_valid", 32'(out_valid), 32'd1);
      chk("lat_out_data", out_data, 32'h11);
      idle(1'b1);
      chk("lat_level_after", 32'(level), 32'd0);

      // Backpressure: two accepted, third waits upstream.
      push(32'h11, 1'b0);
      push(32'h22, 1'b0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_level", 32'(level), 32'd2);
      drive(1'b1, 32'h33, 1'b0, 1'b0, 1'b0, acc);
      drive(1'b1, 32'h33, 1'b0, 1'b0, 1'b0, acc);
      chk("bp_out_data_held", out_data, 32'h11);
      push(32'h33, 1'b1);
      drain();

      // Streaming at full rate.
      for (int i = 1; i <= 8; i++) push(32'(i), 1'b1);
      drain();

      // Flush in FULL overrides a concurrent consume.
      push(32'h51, 1'b0);
      push(32'h52, 1'b0);
      drive(1'b1, 32'h53, 1'b1, 1'b1, 1'b0, acc);
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      chk("flush_level", 32'(level), 32'd0);
      chk("flush_in_ready", 32'(in_ready), 32'd1);
      chk("flush_data_kept", out_data, 32'h51);
      idle(1'b1);

      // Reset in FULL with input offered.
      push(32'hA1, 1'b0);
      push(32'hA2, 1'b0);
      drive(1'b1, 32'hA3, 1'b0, 1'b0, 1'b1, acc);
      chk("rstfull_level", 32'(level), 32'd0);
      chk("rstfull_out_data", out_data, TB_RST);
      idle(1'b1);
      idle(1'b1);

      // Random stalls on both sides.
      sent = 0;
      cyc  = 0;
      pop0 = popped;
      while (sent < 1000 && cyc < 20000) begin
         drive(($urandom_range(0, 3) != 0), 32'h1000_0000 + 32'(sent),
               ($urandom_range(0, 2) != 0), 1'b0, 1'b0, acc);
         if (acc) sent++;
         cyc++;
      end
      chk("rand_sent", 32'(sent), 32'd1000);
      drain();
      chk("rand_popped", 32'(popped - pop0), 32'd1000);

      mon_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/skid_buffer.md
SKID_BUFFER -- requirements
Module: skid_buffer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data width in bits.
REQ-002 The block SHALL have parameter RST_VAL, default 0, giving the reset value of both data registers.
REQ-003 The block SHALL have port clk, input, 1 bit: the clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port flush, input, 1 bit: discards all held entries.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the upstream offers in_data.
REQ-007 The block SHALL have port in_data, input, WIDTH bits: upstream payload.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block can accept this cycle.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_data holds a valid entry.
REQ-010 The block SHALL have port out_data, output, WIDTH bits: head-entry payload.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the downstream consumes this cycle.
REQ-012 The block SHALL have port level, output, 2 bits: occupancy 0..2.

Function
REQ-013 A handshake SHALL occur only when valid and ready are both high at a rising clk edge (in_fire, out_fire).
REQ-014 The state machine SHALL have exactly three states: S_EMPTY (level 0), S_BUSY (level 1), S_FULL (level 2).
REQ-015 Storage SHALL be a main register driving out_data plus one skid register.
REQ-016 Outputs SHALL decode from state only: out_valid = (state != S_EMPTY); in_ready = (state != S_FULL).
REQ-017 There SHALL be no combinational path from out_ready to in_ready or from in_valid to out_valid.
REQ-018 S_EMPTY with in_fire SHALL give main <= in_data and next state S_BUSY; with no in_fire, S_EMPTY SHALL hold.
REQ-019 S_BUSY with in_fire and out_fire SHALL give main <= in_data and remain in S_BUSY.
REQ-020 S_BUSY with in_fire only SHALL give skid <= in_data and next state S_FULL.
REQ-021 S_BUSY with out_fire only SHALL give next state S_EMPTY.
REQ-022 S_BUSY with neither handshake SHALL hold.
REQ-023 S_FULL with out_fire SHALL give main <= skid and next state S_BUSY; S_FULL never accepts input.
REQ-024 S_FULL with no out_fire SHALL hold.
REQ-025 Latency SHALL be 1 cycle: data accepted at edge N appears on out_data with out_valid after edge N.
REQ-026 Sustained throughput SHALL be 1 transfer/cycle while out_ready is held high.
REQ-027 Data order SHALL be preserved with no loss or duplication.
REQ-028 While out_valid=1 and out_ready=0, out_data SHALL remain stable.
REQ-029 flush=1 at an edge SHALL force next state S_EMPTY, override any concurrent handshake, discard any input offered that cycle, and leave data registers unchanged.
REQ-030 flush SHALL not make an upstream in_fire appear lost-then-duplicated; an entry offered during flush is dropped.
REQ-031 Data registers SHALL load only on the enables defined above; no other write path exists.

Reset
REQ-032 rst=1 at an edge SHALL set state S_EMPTY and set main and skid to RST_VAL.
REQ-033 After reset the outputs SHALL be: out_valid=0, in_ready=1, level=0, out_data=RST_VAL.
REQ-034 rst SHALL take priority over flush and over all handshakes; input offered in the rst cycle SHALL be dropped.
REQ-035 Reset mid-operation from any state SHALL discard all entries within one cycle.

Structure
REQ-036 The state typedef skid_state_t (S_EMPTY, S_BUSY, S_FULL) SHALL reside in shared package pipe_pkg.
REQ-037 The main and skid storage SHALL each be an instance of the team's existing enabled register module (WIDTH, RST_VAL passed through), with the block supplying the enables and mux selects.
REQ-038 The next-state/enable logic SHALL be a single combinational process in skid_buffer; no further sub-modules.

Verification
REQ-039 Reset, then push A=0x11 with out_ready=1 -> out_valid=1, out_data=0x11 one cycle later, level=1, then 0 after consumption.
REQ-040 Hold out_ready=0 and push 0x11, 0x22, 0x33 back-to-back -> 0x11 and 0x22 accepted, in_ready=0 after the second accept, level=2, 0x33 held upstream; release out_ready -> output sequence 0x11, 0x22, 0x33 with no gaps once resumed.
REQ-041 Continuous in_valid=1 and out_ready=1 for 8 cycles with data 1..8 -> 8 outputs in order, one per cycle, level=1 throughout.
REQ-042 In S_FULL assert flush together with out_ready=1 -> next cycle out_valid=0, level=0, in_ready=1, and no extra output beat.
REQ-043 Assert rst in S_FULL while in_valid=1 -> next cycle level=0, out_data=RST_VAL, and the offered entry never appears on the output.
REQ-044 Random valid/ready stalls over 1000 transfers -> scoreboard shows an in-order exact match, with out_data stable throughout every stalled cycle.
